seq_divider: RTL

//  Sequential unsigned restoring divider (shift-subtract), one quotient bit per clock.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 40 ++++
 rtl/seq_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e      : controller state encoding (IDLE, CALC, DZ)
//   DefaultWidth : default operand / quotient / remainder width
package div_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DZ   = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   r_i       : partial remainder before the iteration (always < divisor_i)
//   q_i       : dividend/quotient shift register before the iteration
//   divisor_i : divisor
//   r_next_o  : partial remainder after shift + trial subtract
//   q_next_o  : shift register after shift, new quotient bit in bit 0
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_next_o,
  output logic [WIDTH-1:0] q_next_o
);

  // The shifted remainder keeps the bit that falls out of R: with divisors above
  // 2^(WIDTH-1) the value 2R+q can exceed WIDTH bits, and dropping that bit would
  // give a wrong quotient. Since 2R+q < 2*divisor, the difference still fits in
  // WIDTH bits whenever it is non-negative, so trial[WIDTH] is an exact borrow.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;
  logic           borrow;

  always_comb begin
    r_shift = {r_i, q_i[WIDTH-1]};
    trial   = r_shift - {1'b0, divisor_i};
    borrow  = trial[WIDTH];
    if (!borrow) begin
      r_next_o = trial[WIDTH-1:0];
    end else begin
      r_next_o = r_shift[WIDTH-1:0];
    end
    q_next_o = {q_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Quotient = in_a / in_b, Remainder = in_a % in_b; divide-by-zero returns
// all-ones quotient, the dividend as remainder, and raises Div_By_Zero.
// Ports:
//   CLK, RST         : clock (rising edge), asynchronous active-low reset
//   Start            : request, sampled only while idle, with in_a / in_b
//   Quotient         : registered quotient, held until next completion
//   Remainder        : registered remainder, held until next completion
//   Busy             : high while an operation is in progress
//   Quotient_Valid   : one-cycle pulse when results are updated
//   Div_By_Zero      : qualifies the latest result
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Quotient_Valid,
  output logic             Div_By_Zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              valid_q, valid_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  r_next;
  logic [WIDTH-1:0]  q_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .r_i      (r_q),
    .q_i      (q_q),
    .divisor_i(dvsr_q),
    .r_next_o (r_next),
    .q_next_o (q_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    valid_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          q_d     = in_a;
          dvsr_d  = in_b;
          r_d     = '0;
          cnt_d   = '0;
          state_d = (in_b == '0) ? DZ : CALC;
        end
      end
      CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          valid_d     = 1'b1;
          dbz_d       = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      DZ: begin
        // q_q still holds the untouched dividend here.
        quotient_d  = '1;
        remainder_d = q_q;
        dbz_d       = 1'b1;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign Busy           = (state_q != IDLE);
  assign Quotient       = quotient_q;
  assign Remainder      = remainder_q;
  assign Quotient_Valid = valid_q;
  assign Div_By_Zero    = dbz_q;

endmodule
